// File: rtl/call_return_if.sv
// ----------------------------------------------------------------------------
// call_return_if
// Purpose : Bundles the request, stack and status signals of the call/return
//           controller into one port.
// Signals : call_req, ret_req, ret_pc[15:0], call_target[15:0], err_clr
//             requests from the core to the controller
//           push_enable, push_data[7:0], pop_enable, pop_data[7:0]
//             byte-wide stack port (pop_data is the combinational stack top)
//           busy, pc_load, new_pc[15:0], req_err, overflow, underflow,
//           depth[7:0]
//             status back to the core
// Modports: slave  - the controller side
//           master - the core/stack side that drives requests and pop_data
// ----------------------------------------------------------------------------
interface call_return_if;
   logic        call_req;
   logic        ret_req;
   logic [15:0] ret_pc;
   logic [15:0] call_target;
   logic        err_clr;
   logic        push_enable;
   logic [7:0]  push_data;
   logic        pop_enable;
   logic [7:0]  pop_data;
   logic        busy;
   logic        pc_load;
   logic [15:0] new_pc;
   logic        req_err;
   logic        overflow;
   logic        underflow;
   logic [7:0]  depth;

   modport slave (
      input  call_req, ret_req, ret_pc, call_target, err_clr, pop_data,
      output push_enable, push_data, pop_enable, busy, pc_load, new_pc,
             req_err, overflow, underflow, depth
   );

   modport master (
      output call_req, ret_req, ret_pc, call_target, err_clr, pop_data,
      input  push_enable, push_data, pop_enable, busy, pc_load, new_pc,
             req_err, overflow, underflow, depth
   );
endinterface

// File: rtl/call_return_ctrl.sv
// ----------------------------------------------------------------------------
// call_return_ctrl
// Purpose : Sequences subroutine calls and returns over a byte-wide stack.
//           A call pushes the 16-bit return address low byte first, then high
//           byte, and loads the call target. A return pops high then low byte
//           and loads the reassembled address. Rejected requests raise a
//           one-cycle req_err and a sticky overflow/underflow flag.
// Ports   : clk - rising-edge clock
//           rst - asynchronous active-low reset
//           bus - call_return_if.slave (requests, stack port, status)
// Params  : STACK_BYTES - byte capacity of the attached stack
// ----------------------------------------------------------------------------
module call_return_ctrl #(
   parameter int STACK_BYTES = 255
) (
   input  logic          clk,
   input  logic          rst,
   call_return_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE,
      PUSH_LO,
      PUSH_HI,
      POP_HI,
      POP_LO,
      LOAD
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] retPc_q, retPc_d;
   logic [15:0] target_q, target_d;
   logic [7:0]  popHi_q, popHi_d;
   logic [15:0] newPc_q, newPc_d;
   logic [7:0]  depth_q, depth_d;
   logic        reqErr_q, reqErr_d;
   logic        overflow_q, overflow_d;
   logic        underflow_q, underflow_d;

   logic        pushEnable;
   logic [7:0]  pushData;
   logic        popEnable;
   logic        pcLoad;
   logic        ovfSet;
   logic        unfSet;
   int          depthInt;
   logic        callOk;
   logic        retOk;

   // A call needs room for two bytes; a return needs two bytes present.
   // The comparison is done in int so small STACK_BYTES values stay signed.
   assign depthInt = int'(depth_q);
   assign callOk   = (depthInt <= STACK_BYTES - 2);
   assign retOk    = (depth_q >= 8'd2);

   // Next-state and strobe decode. Requests are only looked at in IDLE, so
   // anything raised while busy is simply dropped. A call wins over a return
   // when both arrive together.
   always_comb begin
      state_d    = state_q;
      retPc_d    = retPc_q;
      target_d   = target_q;
      popHi_d    = popHi_q;
      newPc_d    = newPc_q;
      reqErr_d   = 1'b0;
      ovfSet     = 1'b0;
      unfSet     = 1'b0;
      pushEnable = 1'b0;
      pushData   = 8'h00;
      popEnable  = 1'b0;
      pcLoad     = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.call_req) begin
               if (callOk) begin
                  retPc_d  = bus.ret_pc;
                  target_d = bus.call_target;
                  state_d  = PUSH_LO;
               end else begin
                  reqErr_d = 1'b1;
                  ovfSet   = 1'b1;
               end
            end else if (bus.ret_req) begin
               if (retOk) begin
                  state_d = POP_HI;
               end else begin
                  reqErr_d = 1'b1;
                  unfSet   = 1'b1;
               end
            end
         end
         PUSH_LO: begin
            pushEnable = 1'b1;
            pushData   = retPc_q[7:0];
            state_d    = PUSH_HI;
         end
         PUSH_HI: begin
            pushEnable = 1'b1;
            pushData   = retPc_q[15:8];
            newPc_d    = target_q;
            state_d    = LOAD;
         end
         POP_HI: begin
            popEnable = 1'b1;
            popHi_d   = bus.pop_data;
            state_d   = POP_LO;
         end
         POP_LO: begin
            popEnable = 1'b1;
            newPc_d   = {popHi_q, bus.pop_data};
            state_d   = LOAD;
         end
         LOAD: begin
            pcLoad  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Depth tracks the stack strobes and saturates at both ends so it can
   // never wrap. Error flags are sticky; a new error in the same cycle as
   // err_clr keeps the flag set.
   always_comb begin
      depth_d = depth_q;
      if (pushEnable && (depth_q != 8'hFF)) begin
         depth_d = depth_q + 8'd1;
      end else if (popEnable && (depth_q != 8'h00)) begin
         depth_d = depth_q - 8'd1;
      end

      overflow_d = overflow_q;
      if (ovfSet) begin
         overflow_d = 1'b1;
      end else if (bus.err_clr) begin
         overflow_d = 1'b0;
      end

      underflow_d = underflow_q;
      if (unfSet) begin
         underflow_d = 1'b1;
      end else if (bus.err_clr) begin
         underflow_d = 1'b0;
      end
   end

   // State register. Strobes decode from state, so pulling rst low kills
   // them combinationally in the same cycle and any sequence is abandoned.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         retPc_q     <= 16'h0000;
         target_q    <= 16'h0000;
         popHi_q     <= 8'h00;
         newPc_q     <= 16'h0000;
         depth_q     <= 8'h00;
         reqErr_q    <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         retPc_q     <= retPc_d;
         target_q    <= target_d;
         popHi_q     <= popHi_d;
         newPc_q     <= newPc_d;
         depth_q     <= depth_d;
         reqErr_q    <= reqErr_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign bus.push_enable = pushEnable;
   assign bus.push_data   = pushData;
   assign bus.pop_enable  = popEnable;
   assign bus.busy        = (state_q != IDLE);
   assign bus.pc_load     = pcLoad;
   assign bus.new_pc      = newPc_q;
   assign bus.req_err     = reqErr_q;
   assign bus.overflow    = overflow_q;
   assign bus.underflow   = underflow_q;
   assign bus.depth       = depth_q;

endmodule
